// File: rtl/bitop_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : bitop_alu_if
//  Description : Operand/result bundle for the bitop_alu execution unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bitop_alu_if #(
    parameter int DATA_WIDTH = 256
);
    logic [2:0]            opcode;
    logic [DATA_WIDTH-1:0] A_in;
    logic [DATA_WIDTH-1:0] B_in;
    logic [DATA_WIDTH-1:0] Alu_out;

    // Issuing side: presents an operation, observes the registered result.
    modport master (
        output opcode,
        output A_in,
        output B_in,
        input  Alu_out
    );

    // ALU side.
    modport slave (
        input  opcode,
        input  A_in,
        input  B_in,
        output Alu_out
    );
endinterface
`default_nettype wire

// File: rtl/bitop_alu.sv
`default_nettype none
// ============================================================================
//  Module      : bitop_alu
//  Description : Registered bit-manipulation ALU (parity, rotate right/left,
//                population count, bit reverse). Define BITOP_ALU_CLZ_EN to
//                enable count-leading-zeros on opcode 3'b101.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitop_alu #(
    parameter int DATA_WIDTH = 256
) (
    input  wire         clk,
    input  wire         rst,
    bitop_alu_if.slave  bus
);
    localparam int SHW     = $clog2(DATA_WIDTH);
    localparam int c_CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] c_OP_PARITY   = 3'b000;
    localparam logic [2:0] c_OP_ROTR     = 3'b001;
    localparam logic [2:0] c_OP_ROTL     = 3'b010;
    localparam logic [2:0] c_OP_POPCOUNT = 3'b011;
    localparam logic [2:0] c_OP_BITREV   = 3'b100;
    localparam logic [2:0] c_OP_CLZ      = 3'b101;

    logic [SHW-1:0]          w_amt;
    logic [2*DATA_WIDTH-1:0] w_dbl;
    logic [2*DATA_WIDTH-1:0] w_rotr_ext;
    logic [2*DATA_WIDTH-1:0] w_rotl_ext;
    logic [DATA_WIDTH-1:0]   w_rotr;
    logic [DATA_WIDTH-1:0]   w_rotl;
    logic [DATA_WIDTH-1:0]   w_bitrev;
    logic [c_CNT_W-1:0]      w_popcnt;
    logic                    w_parity;
    logic [DATA_WIDTH-1:0]   w_result;
    logic [DATA_WIDTH-1:0]   r_alu_out;

    // Rotations as shifts of the operand concatenated with itself; the upper
    // B_in bits are dropped so the amount wraps modulo DATA_WIDTH.
    assign w_amt      = bus.B_in[SHW-1:0];
    assign w_dbl      = {bus.A_in, bus.A_in};
    assign w_rotr_ext = w_dbl >> w_amt;
    assign w_rotl_ext = w_dbl << w_amt;
    assign w_rotr     = w_rotr_ext[DATA_WIDTH-1:0];
    assign w_rotl     = w_rotl_ext[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_parity   = ^bus.A_in;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bitrev
            assign w_bitrev[gi] = bus.A_in[DATA_WIDTH-1-gi];
        end
    endgenerate

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_popcnt = w_popcnt + c_CNT_W'(bus.A_in[i]);
        end
    end

`ifdef BITOP_ALU_CLZ_EN
    logic [c_CNT_W-1:0] w_clz;

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        w_clz = c_CNT_W'(DATA_WIDTH);
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bus.A_in[i]) begin
                w_clz = c_CNT_W'(DATA_WIDTH - 1 - i);
            end
        end
    end
`endif

    always_comb begin
        w_result = '0;
        case (bus.opcode)
            c_OP_PARITY:   w_result = DATA_WIDTH'(w_parity);
            c_OP_ROTR:     w_result = w_rotr;
            c_OP_ROTL:     w_result = w_rotl;
            c_OP_POPCOUNT: w_result = DATA_WIDTH'(w_popcnt);
            c_OP_BITREV:   w_result = w_bitrev;
`ifdef BITOP_ALU_CLZ_EN
            c_OP_CLZ:      w_result = DATA_WIDTH'(w_clz);
`else
            c_OP_CLZ:      w_result = '0;
`endif
            default:       w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out <= '0;
        end else begin
            r_alu_out <= w_result;
        end
    end

    assign bus.Alu_out = r_alu_out;
endmodule
`default_nettype wire

// File: tb/tb_bitop_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitop_alu
//  Description : Self-checking bench for bitop_alu (directed plus random ops).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitop_alu;
    localparam int DW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bitop_alu_if #(.DATA_WIDTH(DW)) bus ();

    bitop_alu #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: each operation written straight from its bit-index definition.
    function automatic logic [DW-1:0] ref_model(input logic [2:0] op,
                                                input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        logic [DW-1:0] r;
        int n, ones;
        r    = '0;
        n    = int'(b % DW);
        ones = $countones(a);
        case (op)
            3'd0: r = DW'(ones % 2);
            3'd1: for (int i = 0; i < DW; i++) r[i] = a[(i + n) % DW];
            3'd2: for (int i = 0; i < DW; i++) r[(i + n) % DW] = a[i];
            3'd3: r = DW'(ones);
            3'd4: for (int i = 0; i < DW; i++) r[i] = a[DW - 1 - i];
`ifdef BITOP_ALU_CLZ_EN
            3'd5: begin
                int z;
                z = 0;
                while (z < DW && a[DW - 1 - z] == 1'b0) z++;
                r = DW'(z);
            end
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one operation, clock it in, and sample just after the edge.
    task automatic step(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.opcode = op;
        bus.A_in   = a;
        bus.B_in   = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [DW-1:0] a, b, ones_v;
        logic [2:0]    op;
        ones_v = '1;

        rst = 1'b1;
        step(3'd3, ones_v, '0);
        check("reset_edge1", bus.Alu_out, '0);
        step(3'd1, rand_word(), rand_word());
        check("reset_edge2", bus.Alu_out, '0);
        rst = 1'b0;

        step(3'd0, 256'hAC, '0);
        check("parity_AC", bus.Alu_out, '0);
        step(3'd0, 256'hAD, '0);
        check("parity_AD", bus.Alu_out, 256'd1);

        step(3'd3, 256'hAD, '0);
        check("pop_AD", bus.Alu_out, 256'd5);
        step(3'd3, 256'hED, '0);
        check("pop_ED", bus.Alu_out, 256'd6);
        step(3'd3, ones_v, '0);
        check("pop_ones", bus.Alu_out, 256'd256);
        step(3'd3, '0, '0);
        check("pop_zero", bus.Alu_out, '0);

        step(3'd1, 256'hAD, 256'd3);
        check("rotr_3", bus.Alu_out, {3'b101, 248'b0, 5'b10101});
        step(3'd1, 256'hAD, 256'd259);
        check("rotr_259", bus.Alu_out, {3'b101, 248'b0, 5'b10101});

        step(3'd2, {8'hAD, 248'b0}, 256'd3);
        check("rotl_3", bus.Alu_out, {8'h68, 245'b0, 3'b101});
        step(3'd2, {8'hAD, 248'b0}, '0);
        check("rotl_0", bus.Alu_out, {8'hAD, 248'b0});
        step(3'd1, 256'h1234, '0);
        check("rotr_0", bus.Alu_out, 256'h1234);

        step(3'd4, 256'hAD, '0);
        check("bitrev_AD", bus.Alu_out, {8'hB5, 248'b0});
        step(3'd6, ones_v, ones_v);
        check("reserved_110", bus.Alu_out, '0);
        step(3'd7, ones_v, ones_v);
        check("reserved_111", bus.Alu_out, '0);

`ifdef BITOP_ALU_CLZ_EN
        step(3'd5, 256'd1, '0);
        check("clz_one", bus.Alu_out, 256'd255);
        step(3'd5, '0, '0);
        check("clz_zero", bus.Alu_out, 256'd256);
`else
        step(3'd5, 256'd1, '0);
        check("op101_reserved", bus.Alu_out, '0);
`endif

        rst = 1'b1;
        step(3'd3, ones_v, '0);
        check("reset_midstream", bus.Alu_out, '0);
        rst = 1'b0;

        // Back-to-back random operations; each sample must reflect the inputs
        // applied on the immediately preceding edge.
        for (int k = 0; k < 300; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_word();
            b  = rand_word();
            if (k % 10 == 0) a = '0;
            if (k % 10 == 1) a = ones_v;
            if (k % 7 == 0)  a = DW'(1) << $urandom_range(0, DW - 1);
            step(op, a, b);
            check($sformatf("rand%0d_op%0d", k, op), bus.Alu_out, ref_model(op, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
